fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 PCSrcE  in  1  redirect request from execute (taken branch or jump).
REQ-005 PCTargetE  in  32  redirect target.
REQ-006 StallD  in  1  decode cannot accept a new instruction this cycle.
REQ-007 ImemReq  out  1  instruction-memory request valid.
REQ-008 ImemAddr  out  32  request address (PCF).
REQ-009 ImemGnt  in  1  request accepted this cycle.
REQ-010 ImemRValid  in  1  response data valid.
REQ-011 ImemRData  in  32  response instruction word.
REQ-012 ValidD  out  1  InstrD/PCD/PCPlus4D hold a live instruction.
REQ-013 InstrD  out  32  fetched instruction; bits [31:7] feed the immediate extender.
REQ-014 PCD  out  32  address of InstrD.
REQ-015 PCPlus4D  out  32  PCD+4, registered.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, HOLD; exactly one outstanding memory request at any time.
REQ-017 IDLE: one cycle after reset release, then REQ; ImemReq=0.
REQ-018 REQ: ImemReq=1, ImemAddr=PCF; ImemGnt -> WAIT, else remain.
REQ-019 WAIT, ImemRValid with decode free (!ValidD or !StallD): load InstrD=ImemRData, PCD=PCF, PCPlus4D=PCF+4, ValidD=1, PCF=PCF+4, -> REQ.
REQ-020 WAIT, ImemRValid with ValidD=1 and StallD=1: capture word and PC in one-entry skid buffer, -> HOLD.
REQ-021 HOLD: ImemReq=0; when StallD=0, move buffer into D registers, PCF=PCF+4, -> REQ.
REQ-022 D registers hold unchanged while StallD=1; ValidD clears when consumed (StallD=0) with no new instruction loaded.
REQ-023 PCSrcE=1 has priority over all other events: PCF=PCTargetE with bits [1:0] forced to 0; ValidD=0 next cycle; skid buffer discarded.
REQ-024 Redirect in REQ with ImemGnt same cycle, or in WAIT without ImemRValid: set Drop flag, state WAIT.
REQ-025 Redirect in WAIT with ImemRValid same cycle: response discarded, Drop unchanged (0), -> REQ.
REQ-026 WAIT with Drop=1 and ImemRValid: discard response, clear Drop, -> REQ; D registers untouched.
REQ-027 Redirect in IDLE, REQ (no grant) or HOLD: -> REQ with new PCF.
REQ-028 PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 ImemAddr stable while ImemReq=1 and ImemGnt=0 unless redirect.
REQ-030 Best-case throughput one instruction per 2 cycles (grant and response in consecutive cycles).

Reset
REQ-031 rst_n low: state=IDLE, PCF=RESET_PC, Drop=0, ValidD=0, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, skid buffer empty, ImemReq=0.
REQ-032 Reset mid-transaction abandons the outstanding request; responses arriving while state=IDLE are ignored.

Structure
REQ-033 Shared package: fetch_state_t enum, NOP_INSTR constant, XLEN=32.
REQ-034 One sub-module, fetch_skid_buf (one-entry instr+PC buffer, load/unload/clear); all else inline.

Verification
REQ-035 Reset release, Gnt=1 in REQ, RValid next cycle with 32'h00500093 -> ImemAddr 0 then 4; InstrD=32'h00500093, PCD=0, PCPlus4D=4, ValidD=1.
REQ-036 StallD=1 with ValidD=1, response 32'hFFC10113 -> HOLD, InstrD unchanged; StallD=0 -> InstrD=32'hFFC10113, next ImemAddr=PCD+4.
REQ-037 PCSrcE=1, PCTargetE=32'h0000_0102 while in WAIT -> Drop set; next RValid discarded; next ImemAddr=32'h0000_0100; ValidD=0.
REQ-038 PCSrcE and ImemRValid in same cycle -> response discarded, ImemReq=1 at target next cycle.
REQ-039 PCF=32'hFFFF_FFFC fetch completes -> next ImemAddr=0.
REQ-040 rst_n low during WAIT -> ValidD=0, InstrD=NOP, ImemReq=0 asynchronously; late RValid ignored; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: data width, reset
// vector, the NOP word and the fetch FSM state encoding.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    // Sequential successor address; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer holding an instruction word and its PC while decode is
// stalled. clear_i wins over load_i, which wins over unload_i.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    // Buffer occupancy and payload capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps PCF, issues one memory request at a time,
// and delivers words into the decode registers. Handshake: a request is
// transferred on a cycle where ImemReq and ImemGnt are both high; the
// address is held until then; exactly one response (ImemRValid) follows
// each granted request. Redirects flush decode and drop any in-flight
// response with the Drop flag.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRValid,
    input  logic [XLEN-1:0] ImemRData,
    output logic            ValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic [1:0]      state_o,
    output logic            drop_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic            drop_q, drop_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;

    logic            skid_load, skid_unload, skid_valid;
    logic [XLEN-1:0] skid_instr, skid_pc;
    logic            dec_free;

    assign dec_free = !valid_q || !StallD;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (PCSrcE),
        .instr_i  (ImemRData),
        .pc_i     (pcf_q),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    // Next-state logic: redirect first, then per-state fetch progress.
    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        drop_d      = drop_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pcd_d       = pcd_q;
        pcp4_d      = pcp4_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;

        // Decode consumes the live instruction whenever it is not stalled.
        if (valid_q && !StallD) valid_d = 1'b0;

        if (PCSrcE) begin
            pcf_d   = align_pc(PCTargetE);
            valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (ImemGnt) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (ImemRValid) begin
                        // The outstanding response arrives now and is discarded.
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (ImemGnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (ImemRValid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (dec_free) begin
                            instr_d = ImemRData;
                            pcd_d   = pcf_q;
                            pcp4_d  = pc_plus4(pcf_q);
                            valid_d = 1'b1;
                            pcf_d   = pc_plus4(pcf_q);
                            state_d = S_REQ;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!StallD && skid_valid) begin
                        skid_unload = 1'b1;
                        instr_d     = skid_instr;
                        pcd_d       = skid_pc;
                        pcp4_d      = pc_plus4(skid_pc);
                        valid_d     = 1'b1;
                        pcf_d       = pc_plus4(pcf_q);
                        state_d     = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM state, PCF, Drop flag and decode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pcf_q   <= RESET_PC;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pcp4_q  <= '0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
        end
    end

    assign ImemReq  = (state_q == S_REQ);
    assign ImemAddr = pcf_q;
    assign ValidD   = valid_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign state_o  = state_q;
    assign drop_o   = drop_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, normal fetch, stall/skid, redirects
// with and without in-flight responses, PC wrap and mid-transaction reset.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRValid;
    logic [31:0] ImemRData;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [1:0]  state_o;
    logic        drop_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallD     (StallD),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRValid (ImemRValid),
        .ImemRData  (ImemRData),
        .ValidD     (ValidD),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .state_o    (state_o),
        .drop_o     (drop_o)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input fetch_state_t exp);
        chk(tag, 32'(state_o), 32'(exp));
    endtask

    initial begin
        rst_n      = 1'b0;
        PCSrcE     = 1'b0;
        PCTargetE  = '0;
        StallD     = 1'b0;
        ImemGnt    = 1'b0;
        ImemRValid = 1'b0;
        ImemRData  = '0;
        tick();
        tick();

        // Reset state
        chk("rst_req",   32'(ImemReq), 32'd0);
        chk("rst_valid", 32'(ValidD), 32'd0);
        chk("rst_instr", InstrD, 32'h0000_0013);
        chk("rst_pcd",   PCD, 32'h0);
        chk("rst_pcp4",  PCPlus4D, 32'h0);
        chk("rst_addr",  ImemAddr, 32'h0);
        chk_st("rst_state", S_IDLE);

        // Basic fetch from reset PC
        rst_n = 1'b1;
        tick();
        chk_st("idle_to_req", S_REQ);
        chk("req0_req",  32'(ImemReq), 32'd1);
        chk("req0_addr", ImemAddr, 32'h0);
        ImemGnt = 1'b1;
        tick();
        chk_st("gnt_to_wait", S_WAIT);
        chk("wait_req", 32'(ImemReq), 32'd0);
        ImemGnt = 1'b0; ImemRValid = 1'b1; ImemRData = 32'h0050_0093;
        tick();
        ImemRValid = 1'b0;
        chk("f0_valid", 32'(ValidD), 32'd1);
        chk("f0_instr", InstrD, 32'h0050_0093);
        chk("f0_pcd",   PCD, 32'h0);
        chk("f0_pcp4",  PCPlus4D, 32'h4);
        chk("f0_addr",  ImemAddr, 32'h4);
        chk("f0_req",   32'(ImemReq), 32'd1);

        // Stall while a second word arrives -> skid buffer / HOLD
        StallD = 1'b1; ImemGnt = 1'b1;
        tick();
        chk("stall_valid", 32'(ValidD), 32'd1);
        ImemGnt = 1'b0; ImemRValid = 1'b1; ImemRData = 32'hFFC1_0113;
        tick();
        ImemRValid = 1'b0;
        chk_st("hold_state", S_HOLD);
        chk("hold_req",   32'(ImemReq), 32'd0);
        chk("hold_instr", InstrD, 32'h0050_0093);
        tick();
        chk("hold2_instr", InstrD, 32'h0050_0093);
        chk("hold2_pcd",   PCD, 32'h0);
        StallD = 1'b0;
        tick();
        chk("unl_instr", InstrD, 32'hFFC1_0113);
        chk("unl_pcd",   PCD, 32'h4);
        chk("unl_pcp4",  PCPlus4D, 32'h8);
        chk("unl_addr",  ImemAddr, 32'h8);
        chk_st("unl_state", S_REQ);

        // Redirect while waiting with no response -> Drop
        ImemGnt = 1'b1;
        tick();
        chk("consumed_valid", 32'(ValidD), 32'd0);
        ImemGnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
        tick();
        PCSrcE = 1'b0;
        chk("rd_drop",  32'(drop_o), 32'd1);
        chk_st("rd_state", S_WAIT);
        chk("rd_addr",  ImemAddr, 32'h0000_0100);
        ImemRValid = 1'b1; ImemRData = 32'hDEAD_BEEF;
        tick();
        ImemRValid = 1'b0;
        chk("drop_clr",   32'(drop_o), 32'd0);
        chk_st("drop_state", S_REQ);
        chk("drop_valid", 32'(ValidD), 32'd0);
        chk("drop_instr", InstrD, 32'hFFC1_0113);
        chk("drop_addr",  ImemAddr, 32'h0000_0100);

        // Redirect coincident with response
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
        ImemRValid = 1'b1; ImemRData = 32'h1234_5678;
        tick();
        PCSrcE = 1'b0; ImemRValid = 1'b0;
        chk("co_req",   32'(ImemReq), 32'd1);
        chk("co_addr",  ImemAddr, 32'h0000_0200);
        chk("co_drop",  32'(drop_o), 32'd0);
        chk("co_instr", InstrD, 32'hFFC1_0113);
        chk("co_valid", 32'(ValidD), 32'd0);

        // Redirect in REQ with grant the same cycle; unaligned target
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF; ImemGnt = 1'b1;
        tick();
        PCSrcE = 1'b0; ImemGnt = 1'b0;
        chk_st("rg_state", S_WAIT);
        chk("rg_drop", 32'(drop_o), 32'd1);
        chk("rg_addr", ImemAddr, 32'hFFFF_FFFC);
        ImemRValid = 1'b1; ImemRData = 32'h0BAD_0BAD;
        tick();
        ImemRValid = 1'b0;
        chk("rg_valid", 32'(ValidD), 32'd0);
        chk_st("rg_req", S_REQ);

        // Fetch at top of address space wraps
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0; ImemRValid = 1'b1; ImemRData = 32'h0000_0073;
        tick();
        ImemRValid = 1'b0;
        chk("wr_instr", InstrD, 32'h0000_0073);
        chk("wr_pcd",   PCD, 32'hFFFF_FFFC);
        chk("wr_pcp4",  PCPlus4D, 32'h0);
        chk("wr_addr",  ImemAddr, 32'h0);

        // Redirect while holding discards the skid entry
        StallD = 1'b1; ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0; ImemRValid = 1'b1; ImemRData = 32'hAAAA_AAAA;
        tick();
        ImemRValid = 1'b0;
        chk_st("hr_hold", S_HOLD);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0040;
        tick();
        PCSrcE = 1'b0; StallD = 1'b0;
        chk("hr_addr",  ImemAddr, 32'h0000_0040);
        chk("hr_valid", 32'(ValidD), 32'd0);
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0; ImemRValid = 1'b1; ImemRData = 32'h0000_0011;
        tick();
        ImemRValid = 1'b0;
        chk("hr_instr", InstrD, 32'h0000_0011);
        chk("hr_pcd",   PCD, 32'h0000_0040);

        // Asynchronous reset during WAIT with a live decode entry
        StallD = 1'b1; ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        chk("ar_pre_valid", 32'(ValidD), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(ValidD), 32'd0);
        chk("ar_instr", InstrD, 32'h0000_0013);
        chk("ar_req",   32'(ImemReq), 32'd0);
        chk("ar_addr",  ImemAddr, 32'h0);
        StallD = 1'b0; ImemRValid = 1'b1; ImemRData = 32'h0BAD_F00D;
        tick();
        rst_n = 1'b1;
        tick();
        ImemRValid = 1'b0;
        chk("ar_late_valid", 32'(ValidD), 32'd0);
        chk("ar_late_instr", InstrD, 32'h0000_0013);
        chk("ar_late_req",   32'(ImemReq), 32'd1);
        chk("ar_late_addr",  ImemAddr, 32'h0);
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0; ImemRValid = 1'b1; ImemRData = 32'h0010_0093;
        tick();
        ImemRValid = 1'b0;
        chk("ar_f_instr", InstrD, 32'h0010_0093);
        chk("ar_f_pcd",   PCD, 32'h0);
        chk("ar_f_valid", 32'(ValidD), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
